// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: buffer state encodings,
// the transfer-counter width and the per-entry flag bundle.
package alu_result_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int COUNT_W = 16;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_result_stage_flags.sv
// Combinational zero/negative flag generation for an ALU result word.
module alu_flags #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             neg
);

  assign zero = (z == '0);
  assign neg  = z[WIDTH-1];

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: a two-entry skid buffer carrying the result
// with its zero/neg/ovf flags, plus a wrapping count of output transfers.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_z,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic [15:0]      out_count
);

  state_e               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic [WIDTH-1:0]     main_z_q, main_z_d;
  logic [WIDTH-1:0]     skid_z_q, skid_z_d;
  flags_t               main_f_q, main_f_d;
  flags_t               skid_f_q, skid_f_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic                 accept;
  logic                 xfer;
  logic                 in_zero;
  logic                 in_neg;
  flags_t               in_f;

  alu_flags #(.WIDTH(WIDTH)) u_flags (
    .z    (in_z),
    .zero (in_zero),
    .neg  (in_neg)
  );

  assign in_f      = '{zero: in_zero, neg: in_neg, ovf: in_ovf};
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign xfer      = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    main_z_d = main_z_q;
    main_f_d = main_f_q;
    skid_z_d = skid_z_q;
    skid_f_d = skid_f_q;
    count_d  = count_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d  = ST_ONE;
          main_z_d = in_z;
          main_f_d = in_f;
        end
      end
      ST_ONE: begin
        if (accept && !xfer) begin
          state_d  = ST_TWO;
          skid_z_d = in_z;
          skid_f_d = in_f;
        end else if (xfer && !accept) begin
          state_d = ST_EMPTY;
        end else if (accept && xfer) begin
          main_z_d = in_z;
          main_f_d = in_f;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain path is possible
        if (xfer) begin
          state_d  = ST_ONE;
          main_z_d = skid_z_q;
          main_f_d = skid_f_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (xfer) begin
      count_d = count_q + COUNT_W'(1);
    end
    // Registered ready: looks at the next state, never at out_ready directly
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      main_z_q   <= '0;
      main_f_q   <= '0;
      skid_z_q   <= '0;
      skid_f_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_z_q   <= main_z_d;
      main_f_q   <= main_f_d;
      skid_z_q   <= skid_z_d;
      skid_f_q   <= skid_f_d;
      count_q    <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_z     = main_z_q;
  assign out_zero  = main_f_q.zero;
  assign out_neg   = main_f_q.neg;
  assign out_ovf   = main_f_q.ovf;
  assign out_count = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_z;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic        out_zero;
  logic        out_neg;
  logic        out_ovf;
  logic [15:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z      (in_z),
    .in_ovf    (in_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  // advance one rising edge, then settle 1ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_z = '0; in_ovf = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_z = 32'hFFFF_FFFF; in_ovf = 1'b1; out_ready = 1'b1;
    step();
    n_checks++;
    if ({in_ready, out_valid, out_zero, out_neg, out_ovf} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/vld/zero/neg/ovf=%b required 00000",
               {in_ready, out_valid, out_zero, out_neg, out_ovf});
    end
    n_checks++;
    if (out_z !== 32'h0 || out_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: got z=%h cnt=%h required 0/0", out_z, out_count);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b required 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_single_pass();
    in_valid = 1'b1; in_z = 32'h0; in_ovf = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_z = 32'h1234_5678;
    n_checks++;
    if ({out_valid, out_zero, out_neg, out_ovf} !== 4'b1100 || out_z !== 32'h0 ||
        out_count !== 16'd0) begin
      n_fail++;
      $display("FAIL single_out: got vld/zero/neg/ovf=%b z=%h cnt=%0d required 1100 z=0 cnt=0",
               {out_valid, out_zero, out_neg, out_ovf}, out_z, out_count);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_count !== 16'd1) begin
      n_fail++;
      $display("FAIL single_count: got vld=%b cnt=%0d required 0/1", out_valid, out_count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_z = 32'h8000_0000; in_ovf = 1'b0;
    step();
    in_z = 32'h0000_0005;
    step();
    // still offering data while full: must be ignored
    in_z = 32'hDEAD_BEEF; in_ovf = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: got in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
    end
    n_checks++;
    if (out_z !== 32'h8000_0000 || out_neg !== 1'b1 || out_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_head: got z=%h neg=%b zero=%b required 80000000/1/0",
               out_z, out_neg, out_zero);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_z !== 32'h8000_0000 || out_neg !== 1'b1 || out_ovf !== 1'b0 ||
        in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold: got z=%h neg=%b ovf=%b rdy=%b required 80000000/1/0/0",
               out_z, out_neg, out_ovf, in_ready);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_z !== 32'h5 || out_neg !== 1'b0 || in_ready !== 1'b1 ||
        out_count !== 16'd2) begin
      n_fail++;
      $display("FAIL bp_second: got vld=%b z=%h neg=%b rdy=%b cnt=%0d required 1/5/0/1/2",
               out_valid, out_z, out_neg, in_ready, out_count);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_count !== 16'd3) begin
      n_fail++;
      $display("FAIL bp_drain: got vld=%b cnt=%0d required 0/3", out_valid, out_count);
    end
  endtask

  task automatic test_back_to_back();
    int nxt = 0;
    logic [15:0] base;
    base = out_count;
    out_ready = 1'b1;
    for (int c = 0; c <= 100; c++) begin
      if (out_valid === 1'b1) begin
        n_checks++;
        if (out_z !== 32'(1000 + nxt)) begin
          n_fail++;
          $display("FAIL stream_data[%0d]: got %0d required %0d", nxt, out_z, 1000 + nxt);
        end
        nxt++;
      end
      in_valid = (c < 100);
      in_z = 32'(1000 + c);
      in_ovf = 1'b0;
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (nxt != 100 || out_count !== base + 16'd100 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_total: got xfers=%0d cnt_delta=%0d vld=%b required 100/100/0",
               nxt, out_count - base, out_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] base;
    base = out_count;
    out_ready = 1'b0;
    in_valid = 1'b1; in_z = 32'hA; in_ovf = 1'b0;
    step();
    out_ready = 1'b1; in_z = 32'hB; in_ovf = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_z !== 32'hB || out_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_one: got vld=%b rdy=%b z=%h ovf=%b required 1/1/b/1",
               out_valid, in_ready, out_z, out_ovf);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_count !== base + 16'd2) begin
      n_fail++;
      $display("FAIL simul_drain: got vld=%b cnt_delta=%0d required 0/2",
               out_valid, out_count - base);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_z = 32'h11; in_ovf = 1'b0;
    step();
    in_z = 32'h22;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_two: got rdy=%b vld=%b required 0/1", in_ready, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_count !== 16'd0 || in_ready !== 1'b0 || out_z !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_async: got vld=%b cnt=%0d rdy=%b z=%h required 0/0/0/0",
               out_valid, out_count, in_ready, out_z);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_count !== 16'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_stale: got vld=%b cnt=%0d rdy=%b required 0/0/1",
               out_valid, out_count, in_ready);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 65536; c++) begin
      in_valid = 1'b1;
      in_z = (c == 65535) ? 32'hFFFF_FFFF : 32'(c);
      in_ovf = (c == 65535);
      step();
    end
    in_valid = 1'b0; in_ovf = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_ovf !== 1'b1 || out_neg !== 1'b1 ||
        out_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_last: got vld=%b ovf=%b neg=%b cnt=%h required 1/1/1/ffff",
               out_valid, out_ovf, out_neg, out_count);
    end
    step();
    n_checks++;
    if (out_count !== 16'h0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_count: got cnt=%h vld=%b required 0000/0", out_count, out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_z = '0; in_ovf = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single_pass();
    test_backpressure();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
